// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback
// Brief    : Register-bank write sequencer. Merges ALU results with in-order
//            load responses onto one write port and flags load-use hazards.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback #(
    parameter int LQ_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_ready_o,
    input  logic        ld_issue_i,
    input  logic [4:0]  ld_rd_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_signed_i,
    input  logic [1:0]  ld_off_i,
    output logic        ld_full_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic [4:0]  chk1_i,
    input  logic [4:0]  chk2_i,
    output logic        hazard_o,
    output logic        regwrite_o,
    output logic [4:0]  wrreg_o,
    output logic [31:0] wrdata_o,
    output logic        err_o
);

    localparam int                 c_PTR_W = $clog2(LQ_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(LQ_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // Queue payload storage needs no reset: validity comes from the pointers.
    logic [4:0]         r_q_rd   [LQ_DEPTH];
    logic [1:0]         r_q_size [LQ_DEPTH];
    logic               r_q_sgn  [LQ_DEPTH];
    logic [1:0]         r_q_off  [LQ_DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_regwrite;
    logic [4:0]         r_wrreg;
    logic [31:0]        r_wrdata;
    logic               r_err;

    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_alu_take;
    logic               w_err_evt;
    logic [4:0]         w_pop_rd;
    logic [1:0]         w_pop_size;
    logic               w_pop_sgn;
    logic [1:0]         w_pop_off;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ext;
    logic [LQ_DEPTH-1:0] w_hit;

    assign w_empty     = (r_count == '0);
    assign ld_full_o   = (r_count == c_DEPTH) && !mem_rvalid_i;
    assign alu_ready_o = !mem_rvalid_i;
    assign w_push      = ld_issue_i && !ld_full_o;
    assign w_pop       = mem_rvalid_i && !w_empty;
    assign w_alu_take  = alu_valid_i && !mem_rvalid_i;
    assign w_err_evt   = (ld_issue_i && ld_full_o) || (mem_rvalid_i && w_empty);

    assign w_pop_rd    = r_q_rd[r_rd_ptr];
    assign w_pop_size  = r_q_size[r_rd_ptr];
    assign w_pop_sgn   = r_q_sgn[r_rd_ptr];
    assign w_pop_off   = r_q_off[r_rd_ptr];

    always_comb begin
        w_byte = mem_rdata_i[7:0];
        w_half = w_pop_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        w_ext  = mem_rdata_i;
        case (w_pop_off)
            2'd1:    w_byte = mem_rdata_i[15:8];
            2'd2:    w_byte = mem_rdata_i[23:16];
            2'd3:    w_byte = mem_rdata_i[31:24];
            default: w_byte = mem_rdata_i[7:0];
        endcase
        case (w_pop_size)
            2'b00:   w_ext = {{24{w_pop_sgn & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{w_pop_sgn & w_half[15]}}, w_half};
            default: w_ext = mem_rdata_i;
        endcase
    end

    // An entry is live when its distance from the read pointer is below count.
    for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_haz
        localparam logic [c_PTR_W-1:0] c_IDX = c_PTR_W'(gi);
        logic [c_PTR_W-1:0] w_age;
        logic               w_live;
        assign w_age      = c_IDX - r_rd_ptr;
        assign w_live     = ({1'b0, w_age} < r_count);
        assign w_hit[gi]  = w_live && (r_q_rd[gi] != 5'd0) &&
                            ((r_q_rd[gi] == chk1_i) || (r_q_rd[gi] == chk2_i));
    end

    assign hazard_o = |w_hit;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_rd[r_wr_ptr]   <= ld_rd_i;
            r_q_size[r_wr_ptr] <= ld_size_i;
            r_q_sgn[r_wr_ptr]  <= ld_signed_i;
            r_q_off[r_wr_ptr]  <= ld_off_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_regwrite <= 1'b0;
            r_wrreg    <= 5'd0;
            r_wrdata   <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_err_evt) r_err <= 1'b1;
            if (w_pop) begin
                r_regwrite <= (w_pop_rd != 5'd0);
                r_wrreg    <= w_pop_rd;
                r_wrdata   <= w_ext;
            end else if (w_alu_take) begin
                r_regwrite <= (alu_rd_i != 5'd0);
                r_wrreg    <= alu_rd_i;
                r_wrdata   <= alu_data_i;
            end else begin
                r_regwrite <= 1'b0;
            end
        end
    end

    assign regwrite_o = r_regwrite;
    assign wrreg_o    = r_wrreg;
    assign wrdata_o   = r_wrdata;
    assign err_o      = r_err;

endmodule
`default_nettype wire
